// File: rtl/mano_pkg.sv
// ---------------------------------------------------------------------------
// mano_pkg : shared constants and IR field helpers for the Mano sequencer.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mano_pkg;

  // PHASE output encoding
  localparam logic [1:0] PH_FETCH  = 2'd0;
  localparam logic [1:0] PH_DECODE = 2'd1;
  localparam logic [1:0] PH_EXEC   = 2'd2;
  localparam logic [1:0] PH_INTR   = 2'd3;

  // Sequence-count index of the decode cycle and of the first execute cycle
  localparam int DEC_IDX = 2;
  localparam int EXE_IDX = 3;

  // Position of the indirect bit I (MSB of the IR)
  function automatic int ind_bit(input int ir_w);
    return ir_w - 1;
  endfunction

  // Top bit of the opcode field, directly below I
  function automatic int opc_msb(input int ir_w);
    return ir_w - 2;
  endfunction

  // Bottom bit of the opcode field
  function automatic int opc_lsb(input int ir_w, input int opc_w);
    return ir_w - 1 - opc_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mano_onehot_dec.sv
// ---------------------------------------------------------------------------
// mano_onehot_dec : binary to one-hot decoder with enable.
//                   Output is all zeros when disabled.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mano_onehot_dec #(
  parameter int N_W = 3
) (
  input  logic [N_W-1:0]      bin_i,
  input  logic                en_i,
  output logic [2**N_W-1:0]   onehot_o
);

  // Set the single bit selected by bin_i when enabled
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[bin_i] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mano_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mano_seq_ctrl : Mano basic-computer control sequencer. Sequence counter,
//                 timing decode T, registered opcode decode D / indirect bit I,
//                 run flip-flop S, sticky overrun flag and phase reporting.
//                 Build option MANO_INTR_EN enables the interrupt cycle
//                 (R / IEN); without it R and IEN stay 0.
//                 SC_W must be at least 2 so that T2 exists.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mano_seq_ctrl
  import mano_pkg::*;
#(
  parameter int IR_W      = 8,
  parameter int OPC_W     = 3,
  parameter int SC_W      = 3,
  parameter bit START_RUN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [IR_W-1:0]       ir_i,
  input  logic                  sc_clr_i,
  input  logic                  hlt_i,
  input  logic                  start_i,
  input  logic                  ion_i,
  input  logic                  iof_i,
  input  logic                  fgi_i,
  input  logic                  fgo_i,
  output logic [2**SC_W-1:0]    t_o,
  output logic [2**OPC_W-1:0]   d_o,
  output logic                  i_o,
  output logic                  s_o,
  output logic                  r_o,
  output logic                  ien_o,
  output logic [1:0]            phase_o,
  output logic [SC_W-1:0]       sc_o,
  output logic                  sc_err_o
);

  localparam int D_N     = 2**OPC_W;
  localparam int IND_BIT = ind_bit(IR_W);
  localparam int OPC_MSB = opc_msb(IR_W);

  localparam logic [SC_W-1:0] SC_MAX   = '1;
  localparam logic [SC_W-1:0] SC_DEC   = SC_W'(DEC_IDX);
  localparam logic [SC_W-1:0] SC_EXE   = SC_W'(EXE_IDX);
  localparam logic [SC_W-1:0] SC_FETCH = SC_W'(1);

  logic [SC_W-1:0]  sc_q,  sc_d;
  logic             s_q,   s_d;
  logic             r_q,   r_d;
  logic             ien_q, ien_d;
  logic [D_N-1:0]   d_q,   d_d;
  logic             i_q,   i_d;
  logic             err_q, err_d;

  logic [OPC_W-1:0] opc;
  logic [D_N-1:0]   d_dec;

  assign opc = ir_i[OPC_MSB -: OPC_W];

  // Timing signals: one-hot of SC, blanked while halted
  mano_onehot_dec #(.N_W(SC_W)) u_t_dec (
    .bin_i    (sc_q),
    .en_i     (s_q),
    .onehot_o (t_o)
  );

  // Opcode decode feeding the D register
  mano_onehot_dec #(.N_W(OPC_W)) u_d_dec (
    .bin_i    (opc),
    .en_i     (1'b1),
    .onehot_o (d_dec)
  );

  // Only the I bit and opcode field of the IR are consumed here
  logic unused_ir;
  assign unused_ir = ^ir_i;

`ifndef MANO_INTR_EN
  logic unused_intr;
  assign unused_intr = ^{ion_i, iof_i, fgi_i, fgo_i};
`endif

  // Next-state logic for counter, run control, decode and interrupt cycle
  always_comb begin
    sc_d  = sc_q;
    s_d   = s_q;
    r_d   = r_q;
    ien_d = ien_q;
    d_d   = d_q;
    i_d   = i_q;
    err_d = err_q;

    if (s_q) begin
      // Capture the instruction on the T2 edge of a normal (non-interrupt) cycle
      if ((sc_q == SC_DEC) && !r_q) begin
        d_d = d_dec;
        i_d = ir_i[IND_BIT];
      end

      if (hlt_i) begin
        s_d  = 1'b0;
        sc_d = '0;
      end else if (r_q && (sc_q == SC_DEC)) begin
        sc_d = '0;
      end else if (sc_clr_i && !r_q) begin
        sc_d = '0;
      end else if (sc_q == SC_MAX) begin
        sc_d  = '0;
        err_d = 1'b1;
      end else begin
        sc_d = sc_q + 1'b1;
      end

`ifdef MANO_INTR_EN
      if (ion_i) ien_d = 1'b1;
      if (iof_i) ien_d = 1'b0;

      // Request the interrupt cycle during execute; it starts after SC returns to 0
      if (!r_q && !hlt_i && (sc_q >= SC_EXE) && ien_q && (fgi_i || fgo_i)) begin
        r_d = 1'b1;
      end

      // End of interrupt cycle at R.T2; overrides any ION this cycle
      if (r_q && (sc_q == SC_DEC)) begin
        r_d   = 1'b0;
        ien_d = 1'b0;
      end
`endif
    end else begin
      sc_d = '0;
      if (start_i && !hlt_i) begin
        s_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sc_q  <= '0;
      s_q   <= START_RUN;
      r_q   <= 1'b0;
      ien_q <= 1'b0;
      d_q   <= '0;
      i_q   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sc_q  <= sc_d;
      s_q   <= s_d;
      r_q   <= r_d;
      ien_q <= ien_d;
      d_q   <= d_d;
      i_q   <= i_d;
      err_q <= err_d;
    end
  end

  // Phase reporting straight from SC and R
  always_comb begin
    if (r_q) begin
      phase_o = PH_INTR;
    end else if (sc_q <= SC_FETCH) begin
      phase_o = PH_FETCH;
    end else if (sc_q == SC_DEC) begin
      phase_o = PH_DECODE;
    end else begin
      phase_o = PH_EXEC;
    end
  end

  assign d_o      = d_q;
  assign i_o      = i_q;
  assign s_o      = s_q;
  assign r_o      = r_q;
  assign ien_o    = ien_q;
  assign sc_o     = sc_q;
  assign sc_err_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mano_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mano_seq_ctrl : directed self-checking bench for mano_seq_ctrl
//                    (default parameters, START_RUN = 1).
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mano_seq_ctrl;

`ifdef MANO_INTR_EN
  localparam bit INTR = 1'b1;
`else
  localparam bit INTR = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [7:0] ir_i;
  logic       sc_clr_i, hlt_i, start_i, ion_i, iof_i, fgi_i, fgo_i;
  logic [7:0] t_o;
  logic [7:0] d_o;
  logic       i_o, s_o, r_o, ien_o, sc_err_o;
  logic [1:0] phase_o;
  logic [2:0] sc_o;

  int n_chk  = 0;
  int n_fail = 0;

  mano_seq_ctrl #(
    .IR_W(8), .OPC_W(3), .SC_W(3), .START_RUN(1'b1)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .ir_i     (ir_i),
    .sc_clr_i (sc_clr_i),
    .hlt_i    (hlt_i),
    .start_i  (start_i),
    .ion_i    (ion_i),
    .iof_i    (iof_i),
    .fgi_i    (fgi_i),
    .fgo_i    (fgo_i),
    .t_o      (t_o),
    .d_o      (d_o),
    .i_o      (i_o),
    .s_o      (s_o),
    .r_o      (r_o),
    .ien_o    (ien_o),
    .phase_o  (phase_o),
    .sc_o     (sc_o),
    .sc_err_o (sc_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One rising edge, then settle on the falling edge for sampling/driving
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; ir_i = 8'h00;
    sc_clr_i = 0; hlt_i = 0; start_i = 0;
    ion_i = 0; iof_i = 0; fgi_i = 0; fgo_i = 0;
    @(negedge clk_i);
    @(negedge clk_i);

    // Reset state
    check("rst_sc",    sc_o,     0);
    check("rst_s",     s_o,      1);
    check("rst_t",     t_o,      8'h01);
    check("rst_d",     d_o,      0);
    check("rst_i",     i_o,      0);
    check("rst_r",     r_o,      0);
    check("rst_ien",   ien_o,    0);
    check("rst_err",   sc_err_o, 0);
    check("rst_phase", phase_o,  0);
    rst_ni = 1'b1;

    // Free-running walk and wrap with sticky overrun
    for (int k = 1; k < 8; k++) begin
      tick();
      check("walk_t", t_o, 32'h1 << k);
      check("walk_err", sc_err_o, 0);
    end
    tick();
    check("wrap_t",   t_o,      8'h01);
    check("wrap_err", sc_err_o, 1);
    tick();
    check("wrap_t1",     t_o,      8'h02);
    check("err_sticky",  sc_err_o, 1);
    sc_clr_i = 1;
    tick();
    sc_clr_i = 0;
    check("clr_sc", sc_o, 0);

    // Decode of IR=B5 and phase sequence
    ir_i = 8'hB5;
    check("ph0", phase_o, 0);
    tick(); check("ph1", phase_o, 0);
    tick(); check("ph2", phase_o, 1);
    tick(); check("ph3", phase_o, 2);
    check("dec_d", d_o, 8'h08);
    check("dec_i", i_o, 1);
    tick(); check("ph4", phase_o, 2);
    check("sc4", sc_o, 4);
    sc_clr_i = 1;
    tick();
    sc_clr_i = 0;
    check("ph5", phase_o, 0);
    check("eoi_sc", sc_o, 0);
    check("d_hold", d_o, 8'h08);

    // HLT at SC=3, hold, then START
    tick(); tick(); tick();
    check("pre_hlt_sc", sc_o, 3);
    hlt_i = 1;
    tick();
    hlt_i = 0;
    for (int k = 0; k < 5; k++) begin
      check("hlt_s",  s_o,  0);
      check("hlt_t",  t_o,  0);
      check("hlt_sc", sc_o, 0);
      tick();
    end
    start_i = 1;
    tick();
    start_i = 0;
    check("start_s", s_o, 1);
    check("start_t", t_o, 8'h01);
    tick();
    check("start_t1", t_o, 8'h02);

    // HLT and START together: halt wins, running or stopped
    hlt_i = 1; start_i = 1;
    tick();
    check("hs_run_s", s_o, 0);
    tick();
    check("hs_stop_s", s_o, 0);
    hlt_i = 0;
    tick();
    start_i = 0;
    check("restart_s",  s_o,  1);
    check("restart_sc", sc_o, 0);

    // Interrupt cycle
    ion_i = 1; fgi_i = 1; ir_i = 8'h20;
    tick();
    ion_i = 0;
    check("ion_ien", ien_o, INTR ? 1 : 0);
    tick(); tick();
    check("int_sc3", sc_o, 3);
    check("int_d",   d_o,  8'h04);
    check("int_i",   i_o,  0);
    check("int_r0",  r_o,  0);
    sc_clr_i = 1; ir_i = 8'hB5;
    tick();
    check("int_r",   r_o,     INTR ? 1 : 0);
    check("int_ph0", phase_o, INTR ? 3 : 0);
    check("int_sc0", sc_o,    0);
    tick();
    check("int_ph1", phase_o, INTR ? 3 : 0);
    check("int_sc1", sc_o,    INTR ? 1 : 0);
    tick();
    check("int_ph2", phase_o, INTR ? 3 : 0);
    check("int_sc2", sc_o,    INTR ? 2 : 0);
    check("int_r2",  r_o,     INTR ? 1 : 0);
    tick();
    check("int_end_r",   r_o,     0);
    check("int_end_ien", ien_o,   0);
    check("int_end_sc",  sc_o,    0);
    check("int_end_ph",  phase_o, 0);
    check("int_no_dec",  d_o,     8'h04);
    sc_clr_i = 0; fgi_i = 0;

    // IOF wins over ION
    ion_i = 1; iof_i = 1;
    tick();
    ion_i = 0; iof_i = 0;
    check("iof_wins", ien_o, 0);

    // Asynchronous reset mid-instruction at SC=5 with D=08
    tick(); tick(); tick(); tick();
    check("pre_rst_sc",  sc_o,     5);
    check("pre_rst_d",   d_o,      8'h08);
    check("pre_rst_err", sc_err_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_sc",  sc_o,     0);
    check("arst_d",   d_o,      0);
    check("arst_i",   i_o,      0);
    check("arst_err", sc_err_o, 0);
    check("arst_s",   s_o,      1);
    check("arst_t",   t_o,      8'h01);
    check("arst_ph",  phase_o,  0);
    check("arst_r",   r_o,      0);
    check("arst_ien", ien_o,    0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
